// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone B3 round-robin arbiter; the grant is held for a whole CYC so bursts stay intact.
// Define WB_ARB_TIMEOUT_EN to abort an owner whose strobe stalls for TIMEOUT cycles.
module wb_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [1:0]        m_cyc_i,
    input  logic [1:0]        m_stb_i,
    input  logic [1:0]        m_we_i,
    input  logic [2*AW-1:0]   m_adr_i,
    input  logic [2*DW/8-1:0] m_sel_i,
    input  logic [2*DW-1:0]   m_dat_i,
    input  logic [5:0]        m_cti_i,
    input  logic [3:0]        m_bte_i,
    output logic [DW-1:0]     m_dat_o,
    output logic [1:0]        m_ack_o,
    output logic [1:0]        m_err_o,
    output logic [AW-1:0]     m_wb_adr_o,
    output logic [DW/8-1:0]   m_wb_sel_o,
    output logic              m_wb_we_o,
    output logic [DW-1:0]     m_wb_dat_o,
    output logic              m_wb_cyc_o,
    output logic              m_wb_stb_o,
    output logic [2:0]        m_wb_cti_o,
    output logic [1:0]        m_wb_bte_o,
    input  logic [DW-1:0]     m_wb_dat_i,
    input  logic              m_wb_ack_i,
    input  logic              m_wb_err_i,
    output logic [1:0]        grant_o
);
    // state | meaning
    // IDLE  | no owner, slave port quiet, arbitrate on the next edge
    // OWN0  | master 0 drives the slave port until it drops CYC
    // OWN1  | master 1 drives the slave port until it drops CYC
    // ABORT | timed-out owner is cut off until it drops CYC

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_e;

    state_e     state_q;
    logic [1:0] grant_q;
    logic       last_owner_q;
    logic       own_act;
    logic       own;
    logic       tmo_hit;

    assign own_act = (state_q == OWN0) || (state_q == OWN1);
    assign own     = grant_q[1];
    assign grant_o = grant_q;
    assign m_dat_o = m_wb_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_q;
    logic          stall;

    assign stall   = own_act && m_cyc_i[own] && m_stb_i[own] && !m_wb_ack_i && !m_wb_err_i;
    assign tmo_hit = stall && (tmo_q == '0);

    // Down-counter of remaining stalled cycles; STB gaps hold it, any response or release reloads it.
    always_ff @(posedge wb_clk) begin
        if (wb_rst || !own_act || !m_cyc_i[own] || m_wb_ack_i || m_wb_err_i || tmo_hit) begin
            tmo_q <= TW'(TIMEOUT - 1);
        end else if (stall) begin
            tmo_q <= tmo_q - TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        m_wb_cyc_o = 1'b0;
        m_wb_stb_o = 1'b0;
        m_wb_we_o  = 1'b0;
        m_wb_adr_o = '0;
        m_wb_sel_o = '0;
        m_wb_dat_o = '0;
        m_wb_cti_o = '0;
        m_wb_bte_o = '0;
        m_ack_o    = '0;
        m_err_o    = '0;
        if (own_act) begin
            // CYC/STB follow the owner combinationally so the slave sees the release in the same cycle.
            m_wb_cyc_o   = m_cyc_i[own] && !tmo_hit;
            m_wb_stb_o   = m_cyc_i[own] && m_stb_i[own] && !tmo_hit;
            m_wb_we_o    = m_we_i[own];
            m_wb_adr_o   = own ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
            m_wb_sel_o   = own ? m_sel_i[2*SW-1:SW] : m_sel_i[SW-1:0];
            m_wb_dat_o   = own ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0];
            m_wb_cti_o   = own ? m_cti_i[5:3] : m_cti_i[2:0];
            m_wb_bte_o   = own ? m_bte_i[3:2] : m_bte_i[1:0];
            m_ack_o[own] = m_wb_ack_i;
            m_err_o[own] = m_wb_err_i || tmo_hit;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_cyc_i[0] && (!m_cyc_i[1] || last_owner_q)) begin
                        state_q <= OWN0;
                        grant_q <= 2'b01;
                    end else if (m_cyc_i[1]) begin
                        state_q <= OWN1;
                        grant_q <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (!m_cyc_i[own]) begin
                        state_q      <= IDLE;
                        grant_q      <= 2'b00;
                        last_owner_q <= own;
                    end else if (tmo_hit) begin
                        state_q <= ABORT;
                    end
                end
                ABORT: begin
                    if (!m_cyc_i[own]) begin
                        state_q      <= IDLE;
                        grant_q      <= 2'b00;
                        last_owner_q <= own;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule
